// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: widths, instruction field
// positions and the select encodings used by the control path.
package decode_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RD_MSB  = 20;
    localparam int RD_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Immediate extension modes
    typedef enum logic [1:0] {
        IMM_ZERO = 2'b00,
        IMM_SIGN = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_BR   = 2'b11
    } imm_ext_e;

    // Write-back data source
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

    // Read port B address source
    localparam logic RFB_RT = 1'b0;
    localparam logic RFB_RD = 1'b1;

endpackage

// File: rtl/decode_stage_register_file.sv
// 2-read / 1-write register file. R0 always reads zero and ignores
// writes. With BYPASS set, a read of the register being written this
// cycle returns the incoming write data.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_valid;

    // A write is real only when enabled, not to R0 and not swallowed by reset
    assign w_wr_valid = i_we && !i_rst && (i_waddr != '0);

    // Synchronous clear of every register; reset wins over a same-edge write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Combinational read ports with R0 forced to zero and optional forwarding
    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        o_rdata_b = r_regs[i_raddr_b];
        if ((BYPASS != 0) && w_wr_valid && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end
        if ((BYPASS != 0) && w_wr_valid && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
        if (i_raddr_a == '0) begin
            o_rdata_a = '0;
        end
        if (i_raddr_b == '0) begin
            o_rdata_b = '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: splits the fetched instruction into register
// addresses, builds the extended immediate, picks write-back data and
// owns the architectural register file.
import decode_stage_pkg::*;

module decode_stage #(
    parameter int DATA_W   = decode_stage_pkg::DATA_W,
    parameter int ADDR_W   = decode_stage_pkg::ADDR_W,
    parameter int NUM_REGS = decode_stage_pkg::NUM_REGS,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Instr,
    input  logic              RF_WrEn,
    input  logic              RF_WrData_sel,
    input  logic              RF_B_sel,
    input  logic [1:0]        ImmExt,
    input  logic [DATA_W-1:0] ALU_out,
    input  logic [DATA_W-1:0] MEM_out,
    output logic [DATA_W-1:0] Immed,
    output logic [DATA_W-1:0] RF_A,
    output logic [DATA_W-1:0] RF_B
);

    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_rd;
    logic [ADDR_W-1:0] w_rt;
    logic [15:0]       w_imm16;
    logic [ADDR_W-1:0] w_addr_b;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_unused_opcode;

    assign w_rs    = Instr[RS_MSB:RS_LSB];
    assign w_rd    = Instr[RD_MSB:RD_LSB];
    assign w_rt    = Instr[RT_MSB:RT_LSB];
    assign w_imm16 = Instr[IMM_MSB:IMM_LSB];

    // Opcode is decoded further down the pipe, not here
    assign w_unused_opcode = ^Instr[OPC_MSB:OPC_LSB];

    assign w_addr_b  = (RF_B_sel == RFB_RD) ? w_rd : w_rt;
    assign w_wr_data = (RF_WrData_sel == WB_MEM) ? MEM_out : ALU_out;

    // Immediate extension; branch mode sign-fills the top and scales by 4
    always_comb begin
        Immed = '0;
        case (ImmExt)
            IMM_ZERO: Immed = {{(DATA_W-16){1'b0}}, w_imm16};
            IMM_SIGN: Immed = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
            IMM_LUI:  Immed = {w_imm16, {(DATA_W-16){1'b0}}};
            IMM_BR:   Immed = {{(DATA_W-18){w_imm16[15]}}, w_imm16, 2'b00};
            default:  Immed = '0;
        endcase
    end

    register_file #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_register_file (
        .i_clk     (Clk),
        .i_rst     (Reset),
        .i_we      (RF_WrEn),
        .i_waddr   (w_rd),
        .i_wdata   (w_wr_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_addr_b),
        .o_rdata_a (RF_A),
        .o_rdata_b (RF_B)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a reference register-file model predicts read
// data, expectations go through a queue and are popped at each sample.
module tb_decode_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic [1:0]  ImmExt;
    logic [31:0] ALU_out;
    logic [31:0] MEM_out;
    logic [31:0] Immed;
    logic [31:0] RF_A;
    logic [31:0] RF_B;

    logic [31:0] exp_q[$];
    logic [31:0] model_rf [32];
    logic [31:0] e;
    int          checks;
    int          errors;

    decode_stage dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .ImmExt        (ImmExt),
        .ALU_out       (ALU_out),
        .MEM_out       (MEM_out),
        .Immed         (Immed),
        .RF_A          (RF_A),
        .RF_B          (RF_B)
    );

    // Clock and input defaults
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rd,
                                             input logic [15:0] imm16);
        return {6'h00, rs, rd, imm16};
    endfunction

    // Model read: R0 is zero, a live write to the same address forwards
    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic rst, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && !rst && (wa == a)) return wd;
        return model_rf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    endtask

    // Drive a single write over one rising edge, reads idle afterwards
    task automatic drive_write(input logic [4:0] rd, input logic [31:0] data, input logic sel);
        @(negedge Clk);
        Instr         = mk_instr(5'd0, rd, 16'h0);
        RF_WrEn       = 1'b1;
        RF_WrData_sel = sel;
        ALU_out       = sel ? ~data : data;
        MEM_out       = sel ? data : ~data;
        @(posedge Clk);
        if (rd != 5'd0) model_rf[rd] = data;
        @(negedge Clk);
        RF_WrEn = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset   = 1'b1;
        RF_WrEn = 1'b0;
        @(posedge Clk);
        model_clear();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            Instr    = mk_instr(5'(i), 5'd0, {5'(i), 11'h0});
            RF_B_sel = 1'b0;
            exp_q.push_back(model_read(5'(i), 1'b0, 1'b0, 5'd0, 32'h0));
            exp_q.push_back(model_read(5'(i), 1'b0, 1'b0, 5'd0, 32'h0));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (RF_A !== e) begin
                errors++;
                $display("FAIL reset_rf_a r%0d got %h exp %h", i, RF_A, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (RF_B !== e) begin
                errors++;
                $display("FAIL reset_rf_b r%0d got %h exp %h", i, RF_B, e);
            end
        end
    endtask

    task automatic test_write_read();
        drive_write(5'd5, 32'hDEADBEEF, 1'b0);
        drive_write(5'd6, 32'h12345678, 1'b1);
        Instr    = mk_instr(5'd5, 5'd0, {5'd6, 11'h0});
        RF_B_sel = 1'b0;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_A !== e) begin
            errors++;
            $display("FAIL wr_alu_rf_a got %h exp %h", RF_A, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (RF_B !== e) begin
            errors++;
            $display("FAIL wr_mem_rf_b got %h exp %h", RF_B, e);
        end
    endtask

    task automatic test_r0_and_bypass();
        // Write to R0 must read zero both during and after the edge
        @(negedge Clk);
        Instr         = mk_instr(5'd0, 5'd0, 16'h0);
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b0;
        ALU_out       = 32'hFFFFFFFF;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_A !== e) begin
            errors++;
            $display("FAIL r0_bypass got %h exp %h", RF_A, e);
        end
        @(posedge Clk);
        @(negedge Clk);
        RF_WrEn = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_A !== e) begin
            errors++;
            $display("FAIL r0_after_write got %h exp %h", RF_A, e);
        end
        // Same-cycle forward of rd=7 to both ports
        @(negedge Clk);
        Instr         = mk_instr(5'd7, 5'd7, 16'h0);
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b1;
        ALU_out       = 32'hCAFE0007;
        exp_q.push_back(32'hCAFE0007);
        exp_q.push_back(32'hCAFE0007);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_A !== e) begin
            errors++;
            $display("FAIL bypass_rf_a got %h exp %h", RF_A, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (RF_B !== e) begin
            errors++;
            $display("FAIL bypass_rf_b got %h exp %h", RF_B, e);
        end
        @(posedge Clk);
        model_rf[7] = 32'hCAFE0007;
        @(negedge Clk);
        RF_WrEn = 1'b0;
        ALU_out = 32'h0;
        exp_q.push_back(32'hCAFE0007);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_A !== e) begin
            errors++;
            $display("FAIL bypass_stored got %h exp %h", RF_A, e);
        end
    endtask

    task automatic test_immed();
        logic [15:0] imm_tab [2];
        logic [31:0] exp_tab [8];
        imm_tab[0] = 16'h8001;
        imm_tab[1] = 16'h7FFF;
        exp_tab[0] = 32'h00008001; exp_tab[1] = 32'hFFFF8001;
        exp_tab[2] = 32'h80010000; exp_tab[3] = 32'hFFFE0004;
        exp_tab[4] = 32'h00007FFF; exp_tab[5] = 32'h00007FFF;
        exp_tab[6] = 32'h7FFF0000; exp_tab[7] = 32'h0001FFFC;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            Instr  = mk_instr(5'd0, 5'd0, imm_tab[k/4]);
            ImmExt = 2'(k % 4);
            exp_q.push_back(exp_tab[k]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (Immed !== e) begin
                errors++;
                $display("FAIL immed imm=%h mode=%0d got %h exp %h", imm_tab[k/4], k % 4, Immed, e);
            end
        end
    endtask

    task automatic test_b_sel();
        drive_write(5'd9, 32'h99990009, 1'b0);
        Instr    = mk_instr(5'd9, 5'd5, {5'd9, 11'h0});
        RF_B_sel = 1'b1;
        exp_q.push_back(model_rf[5]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_B !== e) begin
            errors++;
            $display("FAIL b_sel_rd got %h exp %h", RF_B, e);
        end
        RF_B_sel = 1'b0;
        exp_q.push_back(model_rf[9]);
        exp_q.push_back(model_rf[9]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (RF_B !== e) begin
            errors++;
            $display("FAIL b_sel_rt got %h exp %h", RF_B, e);
        end
        e = exp_q.pop_front();
        checks++;
        if (RF_A !== e) begin
            errors++;
            $display("FAIL same_addr_rf_a got %h exp %h", RF_A, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rs, rd, rt;
        logic        we, sel, bsel;
        logic [31:0] alu, mem, wd;
        for (int n = 0; n < 60; n++) begin
            @(negedge Clk);
            rs   = 5'($urandom_range(0, 31));
            rd   = 5'($urandom_range(0, 31));
            rt   = 5'($urandom_range(0, 31));
            we   = 1'($urandom_range(0, 1));
            sel  = 1'($urandom_range(0, 1));
            bsel = 1'($urandom_range(0, 1));
            alu  = $urandom();
            mem  = $urandom();
            wd   = sel ? mem : alu;
            Instr         = mk_instr(rs, rd, {rt, 11'($urandom_range(0, 2047))});
            RF_WrEn       = we;
            RF_WrData_sel = sel;
            RF_B_sel      = bsel;
            ALU_out       = alu;
            MEM_out       = mem;
            exp_q.push_back(model_read(rs, we, 1'b0, rd, wd));
            exp_q.push_back(model_read(bsel ? rd : rt, we, 1'b0, rd, wd));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (RF_A !== e) begin
                errors++;
                $display("FAIL b2b_rf_a n=%0d rs=%0d got %h exp %h", n, rs, RF_A, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (RF_B !== e) begin
                errors++;
                $display("FAIL b2b_rf_b n=%0d got %h exp %h", n, RF_B, e);
            end
            @(posedge Clk);
            if (we && rd != 5'd0) model_rf[rd] = wd;
        end
        @(negedge Clk);
        RF_WrEn = 1'b0;
    endtask

    task automatic test_reset_write();
        @(negedge Clk);
        Reset         = 1'b1;
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b0;
        Instr         = mk_instr(5'd0, 5'd3, 16'h0);
        ALU_out       = 32'hA5A5A5A5;
        @(posedge Clk);
        model_clear();
        @(negedge Clk);
        Reset   = 1'b0;
        RF_WrEn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            Instr    = mk_instr(5'(i), 5'(31 - i), {5'(i), 11'h0});
            RF_B_sel = 1'b0;
            exp_q.push_back(model_rf[i]);
            exp_q.push_back(model_rf[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (RF_A !== e) begin
                errors++;
                $display("FAIL rst_wr_rf_a r%0d got %h exp %h", i, RF_A, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (RF_B !== e) begin
                errors++;
                $display("FAIL rst_wr_rf_b r%0d got %h exp %h", i, RF_B, e);
            end
        end
    endtask

    // Test sequence and final report
    initial begin
        checks        = 0;
        errors        = 0;
        Reset         = 1'b0;
        Instr         = 32'h0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ImmExt        = 2'b00;
        ALU_out       = 32'h0;
        MEM_out       = 32'h0;
        model_clear();
        test_reset();
        test_write_read();
        test_r0_and_bypass();
        test_immed();
        test_b_sel();
        test_back_to_back();
        test_reset_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
